// File: rtl/video_pkg.sv
// Shared raster timing sets, pixel types and colour-bar table for the video pipeline.
package video_pkg;

  typedef logic [11:0] coord_t;
  typedef logic [23:0] rgb_t;

  typedef struct packed {
    int   h_active;
    int   h_fp;
    int   h_sync;
    int   h_bp;
    int   v_active;
    int   v_fp;
    int   v_sync;
    int   v_bp;
    logic hs_pol;
    logic vs_pol;
  } timing_t;

  localparam timing_t TIMING_640X480 = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
    hs_pol: 1'b0, vs_pol: 1'b0
  };

  localparam timing_t TIMING_1280X720 = '{
    h_active: 1280, h_fp: 110, h_sync: 40, h_bp: 220,
    v_active: 720,  v_fp: 5,   v_sync: 5,  v_bp: 20,
    hs_pol: 1'b1, vs_pol: 1'b1
  };

  // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
  localparam rgb_t BAR_TABLE [0:7] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

endpackage

// File: rtl/video_delay.sv
// DEPTH-stage shift register with synchronous clear; clear value is the inactive state.
module video_delay #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/video_timing.sv
// Raster counters, pixel request issue, LATENCY-aligned sync/de delay and DVI output register.
module video_timing
  import video_pkg::*;
#(
  parameter int   H_ACTIVE = TIMING_640X480.h_active,
  parameter int   H_FP     = TIMING_640X480.h_fp,
  parameter int   H_SYNC   = TIMING_640X480.h_sync,
  parameter int   H_BP     = TIMING_640X480.h_bp,
  parameter int   V_ACTIVE = TIMING_640X480.v_active,
  parameter int   V_FP     = TIMING_640X480.v_fp,
  parameter int   V_SYNC   = TIMING_640X480.v_sync,
  parameter int   V_BP     = TIMING_640X480.v_bp,
  parameter logic HS_POL   = TIMING_640X480.hs_pol,
  parameter logic VS_POL   = TIMING_640X480.vs_pol,
  parameter int   LATENCY  = 2
) (
  input  logic   I_pix_clk,
  input  logic   I_rst,
  input  logic   I_pattern,
  output logic   O_req,
  output coord_t O_req_x,
  output coord_t O_req_y,
  input  rgb_t   I_pix_rgb,
  output logic   O_frame_start,
  output logic   O_rgb_vs,
  output logic   O_rgb_hs,
  output logic   O_rgb_de,
  output logic [7:0] O_rgb_r,
  output logic [7:0] O_rgb_g,
  output logic [7:0] O_rgb_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int DLY_W   = 3 + $bits(coord_t);

  // Compares run in 13 bits so a sync window ending at 4096 stays representable.
  localparam logic [12:0] H_ACT_END = 13'(H_ACTIVE);
  localparam logic [12:0] HS_START  = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS_END    = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] V_ACT_END = 13'(V_ACTIVE);
  localparam logic [12:0] VS_START  = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VS_END    = 13'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_bad_total
    $error("video_timing: H_TOTAL/V_TOTAL must not exceed 4096");
  end
  if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
    $error("video_timing: LATENCY must be in 1..8");
  end
  if (H_ACTIVE < 8) begin : g_bad_active
    $error("video_timing: H_ACTIVE must be at least 8 for colour bars");
  end

  coord_t h_cnt, v_cnt;
  logic   h_last, v_last;
  logic [12:0] h_ext, v_ext;

  assign h_last = (h_cnt == coord_t'(H_TOTAL - 1));
  assign v_last = (v_cnt == coord_t'(V_TOTAL - 1));
  assign h_ext  = {1'b0, h_cnt};
  assign v_ext  = {1'b0, v_cnt};

  always_ff @(posedge I_pix_clk) begin
    if (I_rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 12'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  logic   req_d, hs_d, vs_d, fs_d;
  logic   req_q, hs_q, vs_q, fs_q;
  coord_t req_x_q, req_y_q;

  assign req_d = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
  assign hs_d  = (h_ext >= HS_START) && (h_ext < HS_END);
  assign vs_d  = (v_ext >= VS_START) && (v_ext < VS_END);
  assign fs_d  = (h_cnt == '0) && (v_cnt == '0);

  always_ff @(posedge I_pix_clk) begin
    if (I_rst) begin
      req_q   <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      fs_q    <= 1'b0;
      req_x_q <= '0;
      req_y_q <= '0;
    end else begin
      req_q   <= req_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fs_q    <= fs_d;
      req_x_q <= req_d ? h_cnt : '0;
      req_y_q <= req_d ? v_cnt : '0;
    end
  end

  assign O_req         = req_q;
  assign O_req_x       = req_x_q;
  assign O_req_y       = req_y_q;
  assign O_frame_start = fs_q;

  logic [DLY_W-1:0] dly_out;
  logic   de_dl, hs_dl, vs_dl;
  coord_t x_dl;

  video_delay #(.DEPTH(LATENCY), .WIDTH(DLY_W)) u_delay (
    .clk   (I_pix_clk),
    .clear (I_rst),
    .din   ({req_q, hs_q, vs_q, req_x_q}),
    .dout  (dly_out)
  );

  assign {de_dl, hs_dl, vs_dl, x_dl} = dly_out;

  // Only the frame-start cycle updates the mode, so a frame never mixes sources.
  logic pattern_q;
  always_ff @(posedge I_pix_clk) begin
    if (I_rst)     pattern_q <= 1'b0;
    else if (fs_q) pattern_q <= I_pattern;
  end

  logic [2:0] bar_idx;
  rgb_t       pix;

  always_comb begin
    bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (x_dl >= coord_t'(i * BAR_W)) bar_idx = 3'(i);
    end
  end

  always_comb begin
    pix = '0;
    if (de_dl) pix = pattern_q ? BAR_TABLE[bar_idx] : I_pix_rgb;
  end

  always_ff @(posedge I_pix_clk) begin
    if (I_rst) begin
      O_rgb_de <= 1'b0;
      O_rgb_hs <= !HS_POL;
      O_rgb_vs <= !VS_POL;
      O_rgb_r  <= '0;
      O_rgb_g  <= '0;
      O_rgb_b  <= '0;
    end else begin
      O_rgb_de <= de_dl;
      O_rgb_hs <= hs_dl ? HS_POL : !HS_POL;
      O_rgb_vs <= vs_dl ? VS_POL : !VS_POL;
      {O_rgb_r, O_rgb_g, O_rgb_b} <= pix;
    end
  end

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing on a 14x7 raster: arithmetic raster model plus a LATENCY-deep pixel source.
module tb_video_timing;

  localparam int   HA = 8, HFP = 2, HSW = 2, HBP = 2;
  localparam int   VA = 4, VFP = 1, VSW = 1, VBP = 1;
  localparam int   LAT = 2;
  localparam logic HS_POL = 1'b0, VS_POL = 1'b0;
  localparam int   HT = HA + HFP + HSW + HBP;
  localparam int   VT = VA + VFP + VSW + VBP;
  localparam int   FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pattern = 1'b0;
  logic [23:0] pix_rgb = 24'h0;
  logic        req, fs, rgb_vs, rgb_hs, rgb_de;
  logic [11:0] req_x, req_y;
  logic [7:0]  rgb_r, rgb_g, rgb_b;

  video_timing #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .LATENCY(LAT)
  ) dut (
    .I_pix_clk(clk), .I_rst(rst), .I_pattern(pattern),
    .O_req(req), .O_req_x(req_x), .O_req_y(req_y),
    .I_pix_rgb(pix_rgb), .O_frame_start(fs),
    .O_rgb_vs(rgb_vs), .O_rgb_hs(rgb_hs), .O_rgb_de(rgb_de),
    .O_rgb_r(rgb_r), .O_rgb_g(rgb_g), .O_rgb_b(rgb_b)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // n = edges since the last reset edge; raster position of a request is n-1,
  // of an output pixel n-LAT-2.
  int          n = 0;
  bit          echo_mode = 1'b1;
  bit          pat_of_frame [int];
  logic [23:0] exp_px [int];
  logic [23:0] hist [$];
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  function automatic bit is_active(int t);
    return (t >= 0) && ((t % HT) < HA) && (((t / HT) % VT) < VA);
  endfunction

  function automatic bit m_req(int nn);        return is_active(nn - 1); endfunction
  function automatic int m_x(int nn);          return m_req(nn) ? (nn - 1) % HT : 0; endfunction
  function automatic int m_y(int nn);          return m_req(nn) ? ((nn - 1) / HT) % VT : 0; endfunction
  function automatic bit m_fs(int nn);         return (nn >= 1) && ((nn - 1) % FRAME == 0); endfunction
  function automatic bit m_de(int nn);         return is_active(nn - LAT - 2); endfunction

  function automatic logic m_hs(int nn);
    int t = nn - LAT - 2;
    bit act = (t >= 0) && ((t % HT) >= HA + HFP) && ((t % HT) < HA + HFP + HSW);
    return act ? HS_POL : !HS_POL;
  endfunction

  function automatic logic m_vs(int nn);
    int t = nn - LAT - 2;
    bit act = (t >= 0) && (((t / HT) % VT) >= VA + VFP) && (((t / HT) % VT) < VA + VFP + VSW);
    return act ? VS_POL : !VS_POL;
  endfunction

  function automatic logic [23:0] m_colour(int nn);
    int t = nn - LAT - 2;
    if (!is_active(t)) return 24'h0;
    if (pat_of_frame.exists(t / FRAME) && pat_of_frame[t / FRAME])
      return bars[(t % HT) / (HA / 8)];
    return exp_px.exists(t) ? exp_px[t] : 24'hDEAD00;
  endfunction

  // One clock: track the raster model at the edge, then act as the pixel source.
  task automatic tick();
    logic [23:0] d;
    @(posedge clk);
    if (rst) begin
      n = 0;
      pat_of_frame.delete();
      exp_px.delete();
      hist.delete();
    end else begin
      if (m_fs(n)) pat_of_frame[(n - 1) / FRAME] = pattern;
      n++;
    end
    @(negedge clk);
    if (m_req(n)) begin
      if (echo_mode) begin
        d = {req_x[7:0], req_y[7:0], 8'hA5};
        exp_px[n - 1] = {8'(m_x(n)), 8'(m_y(n)), 8'hA5};
      end else begin
        d = 24'($urandom);
        exp_px[n - 1] = d;
      end
    end else begin
      d = 24'hFFFFFF;
    end
    hist.push_back(d);
    if (hist.size() > LAT + 1) void'(hist.pop_front());
    pix_rgb = (hist.size() == LAT + 1) ? hist[0] : 24'hFFFFFF;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors += 6;
      if (req !== 1'b0 || fs !== 1'b0) begin
        miscompares++; $display("FAIL reset_req req=%b fs=%b required 0/0", req, fs);
      end
      if (req_x !== 12'd0 || req_y !== 12'd0) begin
        miscompares++; $display("FAIL reset_xy x=%0d y=%0d required 0/0", req_x, req_y);
      end
      if (rgb_de !== 1'b0) begin
        miscompares++; $display("FAIL reset_de got %b required 0", rgb_de);
      end
      if (rgb_hs !== !HS_POL) begin
        miscompares++; $display("FAIL reset_hs got %b required %b", rgb_hs, !HS_POL);
      end
      if (rgb_vs !== !VS_POL) begin
        miscompares++; $display("FAIL reset_vs got %b required %b", rgb_vs, !VS_POL);
      end
      if ({rgb_r, rgb_g, rgb_b} !== 24'h0) begin
        miscompares++; $display("FAIL reset_rgb got %h required 000000", {rgb_r, rgb_g, rgb_b});
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_raster();
    echo_mode = 1'b1;
    pattern = 1'b0;
    for (int c = 0; c < 2 * FRAME + 4; c++) begin
      tick();
      vectors += 7;
      if (req !== m_req(n)) begin
        miscompares++; $display("FAIL raster_req n=%0d got %b required %b", n, req, m_req(n));
      end
      if (req_x !== 12'(m_x(n)) || req_y !== 12'(m_y(n))) begin
        miscompares++;
        $display("FAIL raster_xy n=%0d got %0d,%0d required %0d,%0d", n, req_x, req_y, m_x(n), m_y(n));
      end
      if (fs !== m_fs(n)) begin
        miscompares++; $display("FAIL raster_frame_start n=%0d got %b required %b", n, fs, m_fs(n));
      end
      if (rgb_de !== m_de(n)) begin
        miscompares++; $display("FAIL raster_de n=%0d got %b required %b", n, rgb_de, m_de(n));
      end
      if (rgb_hs !== m_hs(n)) begin
        miscompares++; $display("FAIL raster_hs n=%0d got %b required %b", n, rgb_hs, m_hs(n));
      end
      if (rgb_vs !== m_vs(n)) begin
        miscompares++; $display("FAIL raster_vs n=%0d got %b required %b", n, rgb_vs, m_vs(n));
      end
      if ({rgb_r, rgb_g, rgb_b} !== m_colour(n)) begin
        miscompares++;
        $display("FAIL raster_rgb n=%0d got %h required %h", n, {rgb_r, rgb_g, rgb_b}, m_colour(n));
      end
    end
  endtask

  task automatic test_pattern();
    bit found = 1'b0;
    echo_mode = 1'b0;
    pattern = 1'b0;
    for (int c = 0; c < 2 * FRAME && !found; c++) begin
      tick();
      found = req && (req_x == 12'd3);
    end
    vectors++;
    if (!found) begin
      miscompares++; $display("FAIL pattern_wait_x3 got no request at x=3 required one");
    end
    pattern = 1'b1;
    for (int c = 0; c < 2 * FRAME; c++) begin
      tick();
      vectors += 2;
      if (rgb_de !== m_de(n)) begin
        miscompares++; $display("FAIL pattern_de n=%0d got %b required %b", n, rgb_de, m_de(n));
      end
      if ({rgb_r, rgb_g, rgb_b} !== m_colour(n)) begin
        miscompares++;
        $display("FAIL pattern_rgb n=%0d got %h required %h", n, {rgb_r, rgb_g, rgb_b}, m_colour(n));
      end
    end
    pattern = 1'b0;
  endtask

  task automatic test_reset_midline();
    bit found = 1'b0;
    for (int c = 0; c < 2 * FRAME && !found; c++) begin
      tick();
      found = (rgb_de == 1'b1);
    end
    vectors++;
    if (!found) begin
      miscompares++; $display("FAIL midreset_wait_de got no de required one");
    end
    repeat ($urandom_range(0, 3)) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors += 3;
    if (rgb_de !== 1'b0 || {rgb_r, rgb_g, rgb_b} !== 24'h0) begin
      miscompares++;
      $display("FAIL midreset_out de=%b rgb=%h required 0/000000", rgb_de, {rgb_r, rgb_g, rgb_b});
    end
    if (rgb_hs !== !HS_POL || rgb_vs !== !VS_POL) begin
      miscompares++; $display("FAIL midreset_sync hs=%b vs=%b required inactive", rgb_hs, rgb_vs);
    end
    if (req !== 1'b0 || fs !== 1'b0) begin
      miscompares++; $display("FAIL midreset_req req=%b fs=%b required 0/0", req, fs);
    end
    tick();
    vectors += 2;
    if (req !== 1'b1 || fs !== 1'b1 || req_x !== 12'd0 || req_y !== 12'd0) begin
      miscompares++;
      $display("FAIL midreset_restart req=%b fs=%b x=%0d y=%0d required 1/1/0/0", req, fs, req_x, req_y);
    end
    if (rgb_de !== 1'b0) begin
      miscompares++; $display("FAIL midreset_flush de=%b required 0", rgb_de);
    end
    for (int c = 0; c < FRAME + 10; c++) begin
      tick();
      vectors += 3;
      if (fs !== m_fs(n)) begin
        miscompares++; $display("FAIL midreset_fs n=%0d got %b required %b", n, fs, m_fs(n));
      end
      if (rgb_de !== m_de(n)) begin
        miscompares++; $display("FAIL midreset_de n=%0d got %b required %b", n, rgb_de, m_de(n));
      end
      if ({rgb_r, rgb_g, rgb_b} !== m_colour(n)) begin
        miscompares++;
        $display("FAIL midreset_rgb n=%0d got %h required %h", n, {rgb_r, rgb_g, rgb_b}, m_colour(n));
      end
    end
  endtask

  // Random pixels and random pattern toggles; blanking must always yield black.
  task automatic test_random_traffic();
    echo_mode = 1'b0;
    for (int c = 0; c < 4 * FRAME; c++) begin
      if ($urandom_range(0, 29) == 0) pattern = !pattern;
      tick();
      vectors += 3;
      if (!m_de(n) && {rgb_r, rgb_g, rgb_b} !== 24'h0) begin
        miscompares++;
        $display("FAIL blank_rgb n=%0d got %h required 000000", n, {rgb_r, rgb_g, rgb_b});
      end
      if ({rgb_r, rgb_g, rgb_b} !== m_colour(n)) begin
        miscompares++;
        $display("FAIL random_rgb n=%0d got %h required %h", n, {rgb_r, rgb_g, rgb_b}, m_colour(n));
      end
      if (rgb_hs !== m_hs(n) || rgb_vs !== m_vs(n) || rgb_de !== m_de(n)) begin
        miscompares++;
        $display("FAIL random_sync n=%0d got hs=%b vs=%b de=%b required %b %b %b",
                 n, rgb_hs, rgb_vs, rgb_de, m_hs(n), m_vs(n), m_de(n));
      end
    end
  endtask

  initial begin
    test_reset();
    test_raster();
    test_pattern();
    test_reset_midline();
    test_random_traffic();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/video_timing.md
# video_timing

Raster timing generator and pixel-fetch pipeline sitting directly upstream of the DVI output stage on the pixel clock. It generates horizontal and vertical counters and issues one pixel request per active pixel to a pixel source (framebuffer reader or tile engine) with fixed latency. It re-aligns the returned colour with delayed hsync/vsync/data-enable and drives the encoder's rgb/vs/hs/de inputs. It also provides an internal 8-bar colour test pattern for bring-up without a pixel source.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- HS_POL / VS_POL, 0 / 0, active level of sync (0 = active-low)
- LATENCY, 2, cycles from O_req to valid I_pix_rgb; legal range 1..8
- I_pix_clk  in  1  pixel clock; the only clock
- I_rst  in  1  synchronous, active-high reset
- I_pattern  in  1  1 = internal colour bars, 0 = I_pix_rgb; sampled only at frame start
- O_req  out  1  pixel request, high for every active pixel
- O_req_x  out  12  requested column, 0..H_ACTIVE-1
- O_req_y  out  12  requested row, 0..V_ACTIVE-1
- I_pix_rgb  in  24  {r,g,b} for the request issued LATENCY cycles earlier
- O_frame_start  out  1  one-cycle pulse with the request for (0,0)
- O_rgb_vs / O_rgb_hs / O_rgb_de  out  1 each  to the DVI output stage
- O_rgb_r / O_rgb_g / O_rgb_b  out  8 each  colour to the DVI output stage

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Both must be ≤ 4096; elaboration-time check.
- h_cnt counts 0..H_TOTAL-1. At H_TOTAL-1 it wraps to 0 and v_cnt increments. At v_cnt = V_TOTAL-1 with h_cnt = H_TOTAL-1, both counters wrap to 0.
- Request stage (registered decode of counters):
  - req = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE
  - hs_act = H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC
  - vs_act = V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC
- O_req_x/O_req_y = counters when req; 0 otherwise.
- de, hs_act, vs_act and x[11:0] pass through a LATENCY-deep delay line aligned with I_pix_rgb.
- Output register:
  - O_rgb_de = delayed de.
  - O_rgb_hs = delayed hs_act ? HS_POL : !HS_POL; O_rgb_vs likewise with VS_POL.
  - Colour = 0 when delayed de = 0.
  - Otherwise colour is I_pix_rgb, or, in pattern mode, bar index = delayed x / (H_ACTIVE/8), giving white, yellow, cyan, green, magenta, red, blue, black (components 0xFF/0x00).
- Pattern mode is latched on O_frame_start cycles only; a mid-frame I_pattern change takes effect at the next frame.
- I_pix_rgb is ignored when delayed de = 0. There is no back-pressure; the source must honour LATENCY.

## Timing
- Reset (I_rst high at an edge): counters = 0, delay line cleared to inactive. After that edge:
  - O_req = 0, O_req_x = 0, O_req_y = 0, O_frame_start = 0
  - O_rgb_de = 0, O_rgb_hs = !HS_POL, O_rgb_vs = !VS_POL
  - O_rgb_r/g/b = 0
  - Pattern latch = 0
- First edge with I_rst low: O_req = 1, x = 0, y = 0, O_frame_start = 1.
- I_pix_rgb for that request is sampled LATENCY edges later. O_rgb_* for a pixel appear LATENCY+1 cycles after its O_req.
- Sync/de are delayed identically, so output raster geometry is exact; the frame period is H_TOTAL×V_TOTAL cycles.
- Reset asserted mid-frame: next edge returns to reset values and the pipeline is flushed, so no stale de or colour is emitted afterwards.
- Simultaneous horizontal and vertical wrap: single transition to (0,0) with O_frame_start.

## Structure
- Shared package video_pkg:
  - Timing constant sets for 640x480@60 and 1280x720@60
  - 12-bit coordinate type
  - 24-bit rgb type
  - Colour-bar constant table
- One sub-module, video_delay: parameterised DEPTH×WIDTH shift register with synchronous clear, used for the de/hs/vs/x alignment.

## Test plan
Small geometry for all scenarios: H 8/2/2/2 (H_TOTAL = 14), V 4/1/1/1 (V_TOTAL = 7), LATENCY = 2, active-low syncs.
- Reset release, source echoes {x,y} as rgb → first O_rgb_de = 1 three cycles after first O_req. Each de line is 8 cycles with r/g/b tracking x, then 6 cycles of de = 0.
- Sync geometry → O_rgb_hs low exactly 2 cycles per 14-cycle line, starting 10 cycles after the line's first de. O_rgb_vs low for exactly 14 cycles per 98-cycle frame.
- Frame wrap → O_frame_start every 98 cycles, coincident with O_req x = 0, y = 0. No extra pulse at line wraps.
- I_pattern set at x = 3 mid-frame → current frame unchanged. Next frame shows bars FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000, one pixel each.
- I_rst pulsed for 1 cycle mid-line during de → outputs at reset values the next cycle, and no de for one cycle. Raster then restarts at (0,0) with O_frame_start.
- I_pix_rgb = FFFFFF held constant during blanking → O_rgb_r/g/b = 0 whenever O_rgb_de = 0.
